fir_mac_sequencer: RTL and testbench

Time-multiplexed 15-tap FIR controller for the DDS → multiplier → FIR chain. It accepts 8-bit signed samples over a valid/ready handshake and sequences one shared multiply-accumulate unit across all taps, one tap per clock. It returns a 16-bit signed result bit-exact with the fully parallel FIR. Coefficients are run-time writable between samples.

---
 rtl/fir_mac_sequencer.sv | 133 +++++++++++++
 tb/tb_fir_mac_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed 15-tap FIR: one shared 8x16 MAC stepped over all taps, one tap per clock.
// Define FIR_SEQ_SAT_EN for a 32-bit accumulator with saturation of y; default wraps at 16 bits.
module fir_mac_sequencer (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [7:0]  x,
    input  logic               in_valid,
    output logic               in_ready,
    output logic signed [15:0] y,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic               coef_we,
    input  logic [3:0]         coef_addr,
    input  logic signed [15:0] coef_data,
    output logic               busy
);

    localparam int N = 15;
`ifdef FIR_SEQ_SAT_EN
    localparam int AW = 32;
`else
    localparam int AW = 16;
`endif

    localparam logic signed [15:0] COEF_INIT [N] = '{
        16'sd0, 16'sd3, 16'sd0, -16'sd10, -16'sd15, -16'sd6, 16'sd14, 16'sd29,
        16'sd14, -16'sd6, -16'sd15, -16'sd10, 16'sd0, 16'sd3, 16'sd0
    };

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                state_q, state_d;
    logic signed [7:0]     dly_q  [N];
    logic signed [15:0]    coef_q [N];
    logic [3:0]            wp_q, wp_d;
    logic [3:0]            rd_q, rd_d;
    logic [3:0]            k_q, k_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic signed [15:0]    y_q, y_d;

    logic signed [23:0]    prod;
    logic signed [AW-1:0]  sum;
    logic signed [15:0]    yFinal;
    logic                  accept;
    logic                  coefWrite;

    assign accept    = (state_q == IDLE) && in_valid;
    assign coefWrite = (state_q == IDLE) && coef_we && (coef_addr < 4'(N));

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign y         = y_q;

    // The read index walks backwards from the newest sample so tap k sees x[n-k].
    always_comb begin
        prod = 24'(dly_q[rd_q]) * 24'(coef_q[k_q]);
`ifdef FIR_SEQ_SAT_EN
        sum = acc_q + 32'(prod);
        if (sum > 32'sd32767)
            yFinal = 16'sh7FFF;
        else if (sum < -32'sd32768)
            yFinal = 16'sh8000;
        else
            yFinal = sum[15:0];
`else
        sum    = acc_q + prod[15:0];
        yFinal = sum;
`endif
    end

    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        rd_d    = rd_q;
        k_d     = k_q;
        acc_d   = acc_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rd_d    = wp_q;
                    wp_d    = (wp_q == 4'(N - 1)) ? 4'd0 : wp_q + 4'd1;
                    k_d     = 4'd0;
                    acc_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = sum;
                k_d   = k_q + 4'd1;
                rd_d  = (rd_q == 4'd0) ? 4'(N - 1) : rd_q - 4'd1;
                if (k_q == 4'(N - 1)) begin
                    y_d     = yFinal;
                    k_d     = 4'd0;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wp_q    <= '0;
            rd_q    <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            for (int i = 0; i < N; i++) begin
                dly_q[i]  <= '0;
                coef_q[i] <= COEF_INIT[i];
            end
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            rd_q    <= rd_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            if (accept)
                dly_q[wp_q] <= x;
            if (coefWrite)
                coef_q[coef_addr] <= coef_data;
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: directed scenarios plus randomized samples/coefficients
// compared against a direct convolution model (honours FIR_SEQ_SAT_EN).
module tb_fir_mac_sequencer;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [7:0]  x;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] y;
    logic               out_valid;
    logic               out_ready;
    logic               coef_we;
    logic [3:0]         coef_addr;
    logic signed [15:0] coef_data;
    logic               busy;

    int testCount = 0;
    int failCount = 0;

    int coefM [15];
    int histM [15];
    int impulseRef [15] = '{0, 192, 0, -640, -960, -384, 896, 1856, 896, -384, -960, -640, 0, 192, 0};
    int defaultCoef [15] = '{0, 3, 0, -10, -15, -6, 14, 29, 14, -6, -15, -10, 0, 3, 0};

    fir_mac_sequencer dut (
        .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .in_ready(in_ready),
        .y(y), .out_valid(out_valid), .out_ready(out_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Direct-form convolution over the sample history, newest sample first.
    function automatic logic signed [15:0] modelPush(input int xv);
        longint s;
        logic [63:0] bits;
        for (int i = 14; i > 0; i--) histM[i] = histM[i-1];
        histM[0] = xv;
        s = 0;
        for (int k = 0; k < 15; k++) s += longint'(coefM[k]) * longint'(histM[k]);
`ifdef FIR_SEQ_SAT_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`endif
        bits = 64'(s);
        return bits[15:0];
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < 15; i++) begin
            coefM[i] = defaultCoef[i];
            histM[i] = 0;
        end
    endfunction

    task automatic checkOutput(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    task automatic writeCoef(input int addr, input int data);
        coef_we   = 1'b1;
        coef_addr = 4'(addr);
        coef_data = 16'(data);
        @(negedge clk);
        coef_we = 1'b0;
        if (addr < 15) coefM[addr] = data;
    endtask

    // One full transaction: accept (optionally with a same-edge coefficient write), wait for the
    // result, optionally stall the output and try a write during MAC, then complete the handshake.
    task automatic applyStimulus(input int xs, input int stall, input bit midWrite,
                                 input int wrAddr, input int wrData,
                                 output logic signed [15:0] yObs);
        logic signed [15:0] expY;
        int j;
        checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
        if (wrAddr >= 0) begin
            coef_we   = 1'b1;
            coef_addr = 4'(wrAddr);
            coef_data = 16'(wrData);
            if (wrAddr < 15) coefM[wrAddr] = wrData;
        end
        expY     = modelPush(xs);
        x        = 8'(xs);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        coef_we  = 1'b0;
        checkOutput("in_ready_low", 32'(in_ready), 32'd0);
        j = 0;
        while (!out_valid && j < 40) begin
            if (midWrite && j == 3) begin
                coef_we   = 1'b1;
                coef_addr = 4'd7;
                coef_data = 16'sd100;
            end else begin
                coef_we = 1'b0;
            end
            @(negedge clk);
            j++;
        end
        coef_we = 1'b0;
        checkOutput("latency", 32'(j), 32'd15);
        yObs = y;
        checkOutput("y_model", 32'(y), 32'(expY));
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            x        = 8'($urandom);
            @(negedge clk);
            checkOutput("stall_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_y", 32'(y), 32'(yObs));
            checkOutput("stall_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("out_valid_drop", 32'(out_valid), 32'd0);
        checkOutput("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic signed [15:0] yObs;
        rst = 1'b1; x = '0; in_valid = 1'b0; out_ready = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        modelReset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_y", 32'(y), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 15; i++) begin
            applyStimulus((i == 0) ? 64 : 0, 0, 1'b0, -1, 0, yObs);
            checkOutput("impulse", 32'(yObs), 32'(impulseRef[i]));
        end

        applyStimulus(int'($urandom_range(0, 255)) - 128, 5, 1'b0, -1, 0, yObs);

        doReset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(127, 0, 1'b0, -1, 0, yObs);
            if (i >= 14) checkOutput("step", 32'(yObs), 32'd127);
        end

        doReset();
        for (int i = 0; i < 15; i++) begin
            applyStimulus((i == 0) ? 64 : 0, 0, (i == 7), -1, 0, yObs);
            checkOutput("impulse_midwrite", 32'(yObs), 32'(impulseRef[i]));
        end

        doReset();
        writeCoef(7, 100);
        for (int i = 0; i < 15; i++) begin
            applyStimulus((i == 0) ? 64 : 0, 0, 1'b0, -1, 0, yObs);
            checkOutput("impulse_idlewrite", 32'(yObs), (i == 7) ? 32'sd6400 : 32'(impulseRef[i]));
        end

        x = 8'sd64; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        doReset();
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_y", 32'(y), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 15; i++) begin
            applyStimulus((i == 0) ? 64 : 0, 0, 1'b0, -1, 0, yObs);
            checkOutput("impulse_after_rst", 32'(yObs), 32'(impulseRef[i]));
        end

        for (int i = 0; i < 40; i++) begin
            int wa;
            wa = -1;
            if ($urandom_range(0, 3) == 0) writeCoef(int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)) - 32768);
            if ($urandom_range(0, 4) == 0) wa = int'($urandom_range(0, 15));
            applyStimulus(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                          wa, int'($urandom_range(0, 65535)) - 32768, yObs);
        end

        doReset();
        applyStimulus(127, 0, 1'b0, 0, 32767, yObs);
`ifdef FIR_SEQ_SAT_EN
        checkOutput("overflow", 32'(yObs), 32'sd32767);
`else
        checkOutput("overflow", 32'(yObs), 32'sd32641);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
